// File: rtl/t5_wbarb.sv
// Two-master Wishbone arbiter: iwb/dwb share one memory port, alternating on ties,
// with a per-transaction watchdog that force-completes hung cycles and flags bus_err.
module t5_wbarb #(
  parameter int unsigned TMO = 256
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sys_ena,
  input  logic [29:0] iwb_adr,
  input  logic [3:0]  iwb_sel,
  input  logic        iwb_stb,
  input  logic        iwb_wre,
  output logic [31:0] iwb_dat,
  output logic        iwb_ack,
  input  logic [29:0] dwb_adr,
  input  logic [31:0] dwb_dto,
  input  logic [3:0]  dwb_sel,
  input  logic        dwb_stb,
  input  logic        dwb_wre,
  output logic [31:0] dwb_dti,
  output logic        dwb_ack,
  output logic [29:0] mwb_adr,
  output logic [31:0] mwb_dto,
  output logic [3:0]  mwb_sel,
  output logic        mwb_stb,
  output logic        mwb_wre,
  input  logic [31:0] mwb_dti,
  input  logic        mwb_ack,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [29:0] err_adr
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);
  localparam bit          WDOG_EN  = (TMO != 0);

  state_t      state, state_nx;
  logic        last;   // 1: dwb held the most recent grant
  logic [15:0] wcnt;
  logic        g_i, g_d, tmo_hit, done;

  assign g_i = (state == IGNT);
  assign g_d = (state == DGNT);

  always_comb begin
    mwb_adr = '0;
    mwb_dto = '0;
    mwb_sel = '0;
    mwb_stb = 1'b0;
    mwb_wre = 1'b0;
    if (g_i) begin
      mwb_adr = iwb_adr;
      mwb_sel = iwb_sel;
      mwb_stb = iwb_stb;
      mwb_wre = iwb_wre;
    end else if (g_d) begin
      mwb_adr = dwb_adr;
      mwb_dto = dwb_dto;
      mwb_sel = dwb_sel;
      mwb_stb = dwb_stb;
      mwb_wre = dwb_wre;
    end
  end

  // A real slave ack in the expiry cycle takes precedence over the watchdog.
  assign tmo_hit = WDOG_EN && mwb_stb && !mwb_ack && (wcnt == TMO_LAST);
  assign done    = mwb_stb & (mwb_ack | tmo_hit);

  assign iwb_ack = g_i & done;
  assign dwb_ack = g_d & done;
  assign iwb_dat = (g_i & tmo_hit) ? '0 : mwb_dti;
  assign dwb_dti = (g_d & tmo_hit) ? '0 : mwb_dti;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (sys_ena) begin
          if (iwb_stb && dwb_stb) state_nx = last ? IGNT : DGNT;
          else if (iwb_stb)       state_nx = IGNT;
          else if (dwb_stb)       state_nx = DGNT;
        end
      end
      IGNT, DGNT: begin
        // A dropped strobe aborts the transaction without an ack.
        if (!mwb_stb || done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      last    <= 1'b0;
      wcnt    <= '0;
      bus_err <= 1'b0;
      err_adr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        last <= (state_nx == DGNT);
        wcnt <= '0;
      end else if (state != IDLE && !mwb_ack) begin
        wcnt <= wcnt + 16'd1;
      end
      if (tmo_hit) begin
        bus_err <= 1'b1;
        if (!bus_err) err_adr <= mwb_adr;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_t5_wbarb.sv
// Directed bench for t5_wbarb: single transfers, contention, enable gating,
// watchdog expiry/priority and asynchronous reset mid-transaction.
module tb_t5_wbarb;

  logic        sys_clk = 1'b0;
  logic        sys_rst, sys_ena;
  logic [29:0] iwb_adr, dwb_adr, mwb_adr, err_adr;
  logic [3:0]  iwb_sel, dwb_sel, mwb_sel;
  logic        iwb_stb, iwb_wre, iwb_ack, dwb_stb, dwb_wre, dwb_ack;
  logic [31:0] iwb_dat, dwb_dto, dwb_dti, mwb_dto, mwb_dti;
  logic        mwb_stb, mwb_wre, mwb_ack, err_clr, bus_err;
  logic        ack_drv, auto_ack;

  int n_chk  = 0;
  int n_fail = 0;

  assign mwb_ack = auto_ack ? mwb_stb : ack_drv;

  always #5 sys_clk = ~sys_clk;

  t5_wbarb #(.TMO(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ena(sys_ena),
    .iwb_adr(iwb_adr), .iwb_sel(iwb_sel), .iwb_stb(iwb_stb), .iwb_wre(iwb_wre),
    .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
    .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_stb(dwb_stb),
    .dwb_wre(dwb_wre), .dwb_dti(dwb_dti), .dwb_ack(dwb_ack),
    .mwb_adr(mwb_adr), .mwb_dto(mwb_dto), .mwb_sel(mwb_sel), .mwb_stb(mwb_stb),
    .mwb_wre(mwb_wre), .mwb_dti(mwb_dti), .mwb_ack(mwb_ack),
    .err_clr(err_clr), .bus_err(bus_err), .err_adr(err_adr)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    mwb_dti = 32'h55AA55AA;
    #3;
    n_chk++;
    if ({mwb_stb, mwb_wre, iwb_ack, dwb_ack, bus_err} !== 5'b0 ||
        mwb_adr !== 30'h0 || mwb_dto !== 32'h0 || mwb_sel !== 4'h0 || err_adr !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: stb=%b ack=%b%b err=%b adr=%h eadr=%h, required all 0",
               mwb_stb, iwb_ack, dwb_ack, bus_err, mwb_adr, err_adr);
    end
    n_chk++;
    if (iwb_dat !== 32'h55AA55AA || dwb_dti !== 32'h55AA55AA) begin
      n_fail++;
      $display("FAIL reset_rdata: iwb_dat=%h dwb_dti=%h, required 55aa55aa", iwb_dat, dwb_dti);
    end
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic test_iwb_read();
    tick();
    iwb_adr = 30'h10; iwb_sel = 4'hF; iwb_stb = 1'b1;
    #3;
    n_chk++;
    if (mwb_stb !== 1'b0) begin
      n_fail++; $display("FAIL iread_c0: mwb_stb=%b, required 0", mwb_stb);
    end
    tick();
    ack_drv = 1'b1; mwb_dti = 32'h00000013;
    #3;
    n_chk++;
    if ({mwb_stb, iwb_ack, dwb_ack} !== 3'b110 || mwb_adr !== 30'h10 ||
        iwb_dat !== 32'h13 || mwb_dto !== 32'h0 || mwb_sel !== 4'hF) begin
      n_fail++;
      $display("FAIL iread_c1: stb/iack/dack=%b%b%b adr=%h dat=%h dto=%h, required 110 10 13 0",
               mwb_stb, iwb_ack, dwb_ack, mwb_adr, iwb_dat, mwb_dto);
    end
    tick();
    iwb_stb = 1'b0; ack_drv = 1'b0;
    #3;
    n_chk++;
    if ({mwb_stb, iwb_ack, dwb_ack} !== 3'b000) begin
      n_fail++; $display("FAIL iread_c2: stb/iack/dack=%b%b%b, required 000", mwb_stb, iwb_ack, dwb_ack);
    end
  endtask

  task automatic test_dwb_write();
    int acks = 0;
    tick();
    dwb_adr = 30'h0ABCDE; dwb_sel = 4'h3; dwb_dto = 32'hCAFEBABE; dwb_wre = 1'b1; dwb_stb = 1'b1;
    #3;
    n_chk++;
    if (mwb_stb !== 1'b0) begin
      n_fail++; $display("FAIL dwrite_c0: mwb_stb=%b, required 0", mwb_stb);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      ack_drv = (c == 4);
      #3;
      acks += int'(dwb_ack);
      n_chk++;
      if ({mwb_stb, mwb_wre, mwb_sel} !== 6'b11_0011 || mwb_dto !== 32'hCAFEBABE ||
          mwb_adr !== 30'h0ABCDE || dwb_ack !== (c == 4) || iwb_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL dwrite_c%0d: stb=%b wre=%b sel=%h dto=%h adr=%h dack=%b iack=%b, required 1 1 3 cafebabe 0abcde %b 0",
                 c, mwb_stb, mwb_wre, mwb_sel, mwb_dto, mwb_adr, dwb_ack, iwb_ack, (c == 4));
      end
    end
    tick();
    dwb_stb = 1'b0; dwb_wre = 1'b0; ack_drv = 1'b0;
    #3;
    n_chk++;
    if (mwb_stb !== 1'b0 || acks !== 1) begin
      n_fail++; $display("FAIL dwrite_end: mwb_stb=%b acks=%0d, required 0 1", mwb_stb, acks);
    end
  endtask

  task automatic test_contention();
    // Fresh reset so the first tie follows the reset value of last (dwb first).
    sys_rst = 1'b1;
    #3;
    tick();
    sys_rst = 1'b0;
    iwb_adr = 30'h100; dwb_adr = 30'h200; iwb_stb = 1'b1; dwb_stb = 1'b1; auto_ack = 1'b1;
    for (int c = 0; c < 16; c++) begin
      logic ed, ei;
      logic [29:0] ea;
      if (c != 0) tick();
      #3;
      ed = (c % 4 == 1);
      ei = (c % 4 == 3);
      ea = ed ? 30'h200 : (ei ? 30'h100 : 30'h0);
      n_chk++;
      if ({mwb_stb, iwb_ack, dwb_ack} !== {ed | ei, ei, ed} || mwb_adr !== ea) begin
        n_fail++;
        $display("FAIL contend_c%0d: stb/iack/dack=%b%b%b adr=%h, required %b%b%b %h",
                 c, mwb_stb, iwb_ack, dwb_ack, mwb_adr, ed | ei, ei, ed, ea);
      end
    end
    tick();
    iwb_stb = 1'b0; dwb_stb = 1'b0; auto_ack = 1'b0;
  endtask

  task automatic test_ena();
    tick();
    sys_ena = 1'b0; dwb_adr = 30'h33; dwb_stb = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c != 0) tick();
      if (c == 10) sys_ena = 1'b1;
      ack_drv = (c == 11);
      #3;
      n_chk++;
      if (mwb_stb !== (c == 11) || dwb_ack !== (c == 11)) begin
        n_fail++;
        $display("FAIL ena_c%0d: mwb_stb=%b dwb_ack=%b, required %b", c, mwb_stb, dwb_ack, (c == 11));
      end
    end
    tick();
    dwb_stb = 1'b0; ack_drv = 1'b0;
  endtask

  task automatic wd_run(input logic [29:0] adr, input bit late_ack, input bit clr8,
                        input bit exp_err, input logic [29:0] exp_eadr);
    tick();
    dwb_adr = adr; dwb_wre = 1'b0; dwb_stb = 1'b1; mwb_dti = 32'hDEADBEEF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      ack_drv = late_ack && (c == 8);
      err_clr = clr8 && (c == 8);
      #3;
      n_chk++;
      if (mwb_stb !== 1'b1 || dwb_ack !== (c == 8)) begin
        n_fail++;
        $display("FAIL wd_%h_c%0d: mwb_stb=%b dwb_ack=%b, required 1 %b", adr, c, mwb_stb, dwb_ack, (c == 8));
      end
    end
    n_chk++;
    if (dwb_dti !== (late_ack ? 32'hDEADBEEF : 32'h0)) begin
      n_fail++;
      $display("FAIL wd_%h_data: dwb_dti=%h, required %h", adr, dwb_dti, late_ack ? 32'hDEADBEEF : 32'h0);
    end
    tick();
    dwb_stb = 1'b0; ack_drv = 1'b0; err_clr = 1'b0;
    #3;
    n_chk++;
    if (bus_err !== exp_err || err_adr !== exp_eadr || mwb_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_%h_err: bus_err=%b err_adr=%h mwb_stb=%b, required %b %h 0",
               adr, bus_err, err_adr, mwb_stb, exp_err, exp_eadr);
    end
  endtask

  task automatic test_watchdog();
    wd_run(30'h123, 1'b0, 1'b0, 1'b1, 30'h123);
    // Second expiry keeps the first address; clear in the expiry cycle loses.
    wd_run(30'h456, 1'b0, 1'b1, 1'b1, 30'h123);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #3;
    n_chk++;
    if (bus_err !== 1'b0) begin
      n_fail++; $display("FAIL wd_clear: bus_err=%b, required 0", bus_err);
    end
    wd_run(30'h789, 1'b1, 1'b0, 1'b0, 30'h123);
  endtask

  task automatic test_reset_mid();
    tick();
    iwb_adr = 30'h2A; iwb_stb = 1'b1;
    tick();
    #3;
    n_chk++;
    if (mwb_stb !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_c1: mwb_stb=%b, required 1", mwb_stb);
    end
    tick();
    ack_drv = 1'b1; mwb_dti = 32'h77;
    #1;
    sys_rst = 1'b1;
    #2;
    n_chk++;
    if ({mwb_stb, iwb_ack, dwb_ack} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_async: stb/iack/dack=%b%b%b, required 000", mwb_stb, iwb_ack, dwb_ack);
    end
    tick();
    sys_rst = 1'b0; ack_drv = 1'b0;
    #3;
    n_chk++;
    if (mwb_stb !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: mwb_stb=%b, required 0", mwb_stb);
    end
    tick();
    ack_drv = 1'b1;
    #3;
    n_chk++;
    if ({mwb_stb, iwb_ack} !== 2'b11 || mwb_adr !== 30'h2A || iwb_dat !== 32'h77) begin
      n_fail++;
      $display("FAIL rstmid_regrant: stb/iack=%b%b adr=%h dat=%h, required 11 2a 77",
               mwb_stb, iwb_ack, mwb_adr, iwb_dat);
    end
    tick();
    iwb_stb = 1'b0; ack_drv = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; sys_ena = 1'b1; err_clr = 1'b0;
    iwb_adr = '0; iwb_sel = '0; iwb_stb = 1'b0; iwb_wre = 1'b0;
    dwb_adr = '0; dwb_dto = '0; dwb_sel = '0; dwb_stb = 1'b0; dwb_wre = 1'b0;
    mwb_dti = '0; ack_drv = 1'b0; auto_ack = 1'b0;
    tick();
    test_reset();
    test_iwb_read();
    test_dwb_write();
    test_contention();
    test_ena();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
